// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the in-order RV core.
// Owns the PC and issues credit-limited requests to instruction memory.
// Buffers in-order responses and drives the IF/ID pipeline register.
// Optional performance counters are compiled in when IF_FETCH_PERF_EN is defined.
module if_fetch_unit #(
  parameter int unsigned                PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC    = '0,
  parameter int unsigned                FETCH_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [PC_WIDTH-1:0] id_inst,
  output logic                stall_req_if
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]         perf_starve_cnt,
  output logic [31:0]         perf_discard_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FETCH_DEPTH + 1);
  // Wide enough to hold the sum of three counters without overflow.
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [PC_WIDTH-1:0] NOP_INST = PC_WIDTH'(32'h0000_0013);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    discard_q, discard_d;
  logic [CNT_W-1:0]    buf_cnt_q, buf_cnt_d;
  logic [PC_WIDTH-1:0] pcq_q [FETCH_DEPTH];
  logic [PC_WIDTH-1:0] pcq_d [FETCH_DEPTH];
  logic [PC_WIDTH-1:0] rb_pc_q [FETCH_DEPTH];
  logic [PC_WIDTH-1:0] rb_pc_d [FETCH_DEPTH];
  logic [PC_WIDTH-1:0] rb_inst_q [FETCH_DEPTH];
  logic [PC_WIDTH-1:0] rb_inst_d [FETCH_DEPTH];
  logic                id_valid_q, id_valid_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [PC_WIDTH-1:0] id_inst_q, id_inst_d;

  logic credit_ok, issue, rsp_drop, rsp_take, rb_push, rb_pop;
  logic unused_bits;

  assign unused_bits = ^{stall[4:2], redirect_pc[1:0]};

  // Issue handshake and response classification.
  always_comb begin
    credit_ok = (SUM_W'(inflight_q) + SUM_W'(discard_q) + SUM_W'(buf_cnt_q)) < SUM_W'(FETCH_DEPTH);
    imem_req  = !rst && !redirect_valid && credit_ok;
    imem_addr = pc_q;
    issue     = imem_req && imem_gnt;
    rsp_drop  = imem_rvalid && (discard_q != '0);
    // A response with nothing outstanding is stray and ignored.
    rsp_take  = imem_rvalid && (discard_q == '0) && (inflight_q != '0);
    rb_push   = rsp_take && !redirect_valid;
    rb_pop    = !redirect_valid && !stall[1] && !stall[0] && (buf_cnt_q != '0);
    stall_req_if = (buf_cnt_q == '0) && !redirect_valid;
  end

  // PC, credit counters and redirect flush.
  always_comb begin
    pc_d       = issue ? pc_q + PC_WIDTH'(4) : pc_q;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(rsp_take);
    discard_d  = discard_q - CNT_W'(rsp_drop);
    buf_cnt_d  = buf_cnt_q + CNT_W'(rb_push) - CNT_W'(rb_pop);
    if (redirect_valid) begin
      pc_d       = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight_d = '0;
      buf_cnt_d  = '0;
      // Any response landing this cycle consumes one outstanding slot, either
      // an already-discarded one or one of the in-flight fetches being killed.
      discard_d  = discard_q + inflight_q - CNT_W'(rsp_drop || rsp_take);
    end
  end

  // Issued-PC queue and response buffer: shift-out head, append at tail.
  always_comb begin
    pcq_d     = pcq_q;
    rb_pc_d   = rb_pc_q;
    rb_inst_d = rb_inst_q;
    if (rsp_take) begin
      for (int i = 0; i < int'(FETCH_DEPTH) - 1; i++) pcq_d[i] = pcq_q[i + 1];
    end
    if (issue) begin
      for (int i = 0; i < int'(FETCH_DEPTH); i++) begin
        if (i == int'(inflight_q) - int'(rsp_take)) pcq_d[i] = pc_q;
      end
    end
    if (rb_pop) begin
      for (int i = 0; i < int'(FETCH_DEPTH) - 1; i++) begin
        rb_pc_d[i]   = rb_pc_q[i + 1];
        rb_inst_d[i] = rb_inst_q[i + 1];
      end
    end
    if (rb_push) begin
      for (int i = 0; i < int'(FETCH_DEPTH); i++) begin
        if (i == int'(buf_cnt_q) - int'(rb_pop)) begin
          rb_pc_d[i]   = pcq_q[0];
          rb_inst_d[i] = imem_rdata;
        end
      end
    end
  end

  // IF/ID register update: redirect > ID stall > deliver > bubble.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (redirect_valid) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (stall[1]) begin
      id_valid_d = id_valid_q;
    end else if (rb_pop) begin
      id_valid_d = 1'b1;
      id_pc_d    = rb_pc_q[0];
      id_inst_d  = rb_inst_q[0];
    end else begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      buf_cnt_q  <= '0;
      for (int i = 0; i < int'(FETCH_DEPTH); i++) begin
        pcq_q[i]     <= '0;
        rb_pc_q[i]   <= '0;
        rb_inst_q[i] <= '0;
      end
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      buf_cnt_q  <= buf_cnt_d;
      pcq_q      <= pcq_d;
      rb_pc_q    <= rb_pc_d;
      rb_inst_q  <= rb_inst_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] starve_q, drop_q;
  logic        dropped;

  // A response is dropped if already marked for discard or killed by a same-cycle redirect.
  assign dropped = rsp_drop || (redirect_valid && rsp_take);

  // Saturating starvation and discard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      drop_q   <= '0;
    end else begin
      if (stall_req_if && (starve_q != 32'hFFFF_FFFF)) starve_q <= starve_q + 32'd1;
      if (dropped && (drop_q != 32'hFFFF_FFFF))        drop_q   <= drop_q + 32'd1;
    end
  end

  assign perf_starve_cnt  = starve_q;
  assign perf_discard_cnt = drop_q;
`endif

endmodule
